// File: rtl/dram_arb_pkg.sv
// Shared types and slot/tick constants for the CPC DRAM time-slot arbiter.
// Owner encoding matches the 2-bit owner output: IDLE=0, VID=1, CPU=2, AUX=3.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        CPU  = 2'd2,
        AUX  = 2'd3
    } owner_t;

    localparam logic [1:0] SLOT_VID0 = 2'd0;
    localparam logic [1:0] SLOT_CPU  = 2'd1;
    localparam logic [1:0] SLOT_VID1 = 2'd2;
    localparam logic [1:0] SLOT_AUX  = 2'd3;

    localparam logic [1:0] TICK_GRANT  = 2'd0;
    localparam logic [1:0] TICK_WE_ON  = 2'd1;
    localparam logic [1:0] TICK_WE_OFF = 2'd3;
    localparam logic [1:0] TICK_SAMPLE = 2'd3;

    // Fixed slot map; with steal enabled, otherwise-idle slots 0..2 fall to AUX.
    function automatic owner_t pick_owner(input logic [1:0] slot,
                                          input logic       vid_en,
                                          input logic       cpu_req,
                                          input logic       aux_req,
                                          input logic       steal_en);
        owner_t o;
        o = IDLE;
        case (slot)
            SLOT_CPU: begin
                if (cpu_req)                  o = CPU;
                else if (steal_en && aux_req) o = AUX;
            end
            SLOT_AUX: begin
                if (aux_req) o = AUX;
            end
            default: begin
                if (vid_en)                   o = VID;
                else if (steal_en && aux_req) o = AUX;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dram_slot_timer.sv
// Phase counter for the 16-tick microsecond frame plus the per-tick edge strobes.
// Edge strobes fire on the clk edge that enters (grant/we) or closes (sample) a tick.
module dram_slot_timer
    import dram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       RESET_N,
    input  logic       cen_16,
    output logic [3:0] phase,
    output logic [1:0] grant_slot,
    output logic       grant_edge,
    output logic       we_on_edge,
    output logic       we_off_edge,
    output logic       sample_edge
);

    logic [3:0] phase_q, phase_d;
    logic       first_q, first_d;
    logic [3:0] phase_inc;

    assign phase_inc = phase_q + 4'd1;

    always_comb begin
        phase_d = phase_q;
        first_d = first_q;
        if (cen_16) begin
            phase_d = phase_inc;
            first_d = 1'b0;
        end
    end

    // The very first tick after reset grants slot 0 so the first frame is usable.
    assign grant_edge  = cen_16 && ((phase_inc[1:0] == TICK_GRANT) || first_q);
    assign grant_slot  = first_q ? SLOT_VID0 : phase_inc[3:2];
    assign we_on_edge  = cen_16 && (phase_inc[1:0] == TICK_WE_ON);
    assign we_off_edge = cen_16 && (phase_inc[1:0] == TICK_WE_OFF);
    assign sample_edge = cen_16 && (phase_q[1:0] == TICK_SAMPLE);
    assign phase       = phase_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            phase_q <= 4'd0;
            first_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/dram_slot_arbiter.sv
// Four-slot DRAM port arbiter: VID even byte, CPU, VID odd byte, AUX per microsecond.
// Optional macro AUX_STEAL_EN lets AUX take idle CPU and video slots.
module dram_slot_arbiter
    import dram_arb_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          RESET_N,
    input  logic          cen_16,
    input  logic          vid_en,
    input  logic [AW-2:0] vid_addr,
    output logic [15:0]   vid_data,
    output logic          vid_strobe,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [7:0]    aux_wdata,
    output logic [7:0]    aux_rdata,
    output logic          aux_ack,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    output logic          ram_oe,
    output logic          ram_we,
    output logic [3:0]    phase,
    output logic [1:0]    owner
);

`ifdef AUX_STEAL_EN
    localparam logic STEAL_EN = 1'b1;
`else
    localparam logic STEAL_EN = 1'b0;
`endif

    logic [1:0] grant_slot;
    logic       grant_edge, we_on_edge, we_off_edge, sample_edge;

    dram_slot_timer u_timer (
        .clk         (clk),
        .RESET_N     (RESET_N),
        .cen_16      (cen_16),
        .phase       (phase),
        .grant_slot  (grant_slot),
        .grant_edge  (grant_edge),
        .we_on_edge  (we_on_edge),
        .we_off_edge (we_off_edge),
        .sample_edge (sample_edge)
    );

    owner_t        owner_q, owner_d, grant;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]    ram_wdata_q, ram_wdata_d;
    logic          ram_oe_q, ram_oe_d;
    logic          ram_we_q, ram_we_d;
    logic          dir_q, dir_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [7:0]    aux_rdata_q, aux_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          aux_ack_q, aux_ack_d;
    logic [7:0]    vid_lo_q, vid_lo_d;
    logic          vid_ok_q, vid_ok_d;
    logic [15:0]   vid_data_q, vid_data_d;
    logic          vid_strobe_q, vid_strobe_d;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        owner_d      = owner_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_oe_d     = ram_oe_q;
        ram_we_d     = ram_we_q;
        dir_d        = dir_q;
        cpu_rdata_d  = cpu_rdata_q;
        aux_rdata_d  = aux_rdata_q;
        cpu_ack_d    = 1'b0;
        aux_ack_d    = 1'b0;
        vid_lo_d     = vid_lo_q;
        vid_ok_d     = vid_ok_q;
        vid_data_d   = vid_data_q;
        vid_strobe_d = 1'b0;
        grant        = pick_owner(grant_slot, vid_en, cpu_req, aux_req, STEAL_EN);

        // Closing edge of the current slot: capture read data for its owner.
        if (sample_edge) begin
            case (owner_q)
                VID: begin
                    if (phase[3:2] == SLOT_VID0) begin
                        vid_lo_d = ram_rdata;
                    end else if (vid_ok_q) begin
                        vid_data_d   = {ram_rdata, vid_lo_q};
                        vid_strobe_d = 1'b1;
                    end
                end
                CPU: begin
                    if (!dir_q) cpu_rdata_d = ram_rdata;
                    cpu_ack_d = 1'b1;
                end
                AUX: begin
                    if (!dir_q) aux_rdata_d = ram_rdata;
                    aux_ack_d = 1'b1;
                end
                default: ;
            endcase
            if (phase[3:2] == SLOT_VID0) vid_ok_d = (owner_q == VID);
        end

        // Same edge opens the next slot; an IDLE grant keeps the old address.
        if (grant_edge) begin
            owner_d  = grant;
            ram_oe_d = 1'b0;
            dir_d    = 1'b0;
            case (grant)
                VID: begin
                    ram_addr_d = {vid_addr, (grant_slot == SLOT_VID1)};
                    ram_oe_d   = 1'b1;
                end
                CPU: begin
                    ram_addr_d  = cpu_addr;
                    ram_wdata_d = cpu_wdata;
                    dir_d       = cpu_we;
                    ram_oe_d    = !cpu_we;
                end
                AUX: begin
                    ram_addr_d  = aux_addr;
                    ram_wdata_d = aux_wdata;
                    dir_d       = aux_we;
                    ram_oe_d    = !aux_we;
                end
                default: ;
            endcase
        end

        if (we_on_edge)  ram_we_d = dir_d;
        if (we_off_edge) ram_we_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            owner_q      <= IDLE;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_oe_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            dir_q        <= 1'b0;
            cpu_rdata_q  <= '0;
            aux_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            aux_ack_q    <= 1'b0;
            vid_lo_q     <= '0;
            vid_ok_q     <= 1'b0;
            vid_data_q   <= '0;
            vid_strobe_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_oe_q     <= ram_oe_d;
            ram_we_q     <= ram_we_d;
            dir_q        <= dir_d;
            cpu_rdata_q  <= cpu_rdata_d;
            aux_rdata_q  <= aux_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            aux_ack_q    <= aux_ack_d;
            vid_lo_q     <= vid_lo_d;
            vid_ok_q     <= vid_ok_d;
            vid_data_q   <= vid_data_d;
            vid_strobe_q <= vid_strobe_d;
        end
    end

    assign owner      = owner_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_oe     = ram_oe_q;
    assign ram_we     = ram_we_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign aux_rdata  = aux_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign aux_ack    = aux_ack_q;
    assign vid_data   = vid_data_q;
    assign vid_strobe = vid_strobe_q;

endmodule

// File: tb/tb_dram_slot_arbiter.sv
// Directed bench for dram_slot_arbiter with a byte RAM model and per-master
// scoreboards; cen_16 runs at half the clk rate so freezing is exercised.
module tb_dram_slot_arbiter;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          RESET_N = 1'b0;
    logic          cen_16 = 1'b0;
    logic          vid_en = 1'b0;
    logic [AW-2:0] vid_addr = '0;
    logic [15:0]   vid_data;
    logic          vid_strobe;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;
    logic          aux_req = 1'b0, aux_we = 1'b0;
    logic [AW-1:0] aux_addr = '0;
    logic [7:0]    aux_wdata = '0;
    logic [7:0]    aux_rdata;
    logic          aux_ack;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic          ram_oe, ram_we;
    logic [3:0]    phase;
    logic [1:0]    owner;

    dram_slot_arbiter #(.AW(AW)) dut (
        .clk        (clk),
        .RESET_N    (RESET_N),
        .cen_16     (cen_16),
        .vid_en     (vid_en),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .vid_strobe (vid_strobe),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_rdata  (aux_rdata),
        .aux_ack    (aux_ack),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_oe     (ram_oe),
        .ram_we     (ram_we),
        .phase      (phase),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 cen_16 = ~cen_16;
        end
    end

    // Byte RAM; preload is reapplied whenever reset is held.
    logic [7:0] mem [0:65535];
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (!RESET_N) begin
            mem[16'h2000] <= 8'hA5;
            mem[16'h2001] <= 8'h5A;
            mem[16'h4000] <= 8'h3C;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    typedef struct {
        logic        chk;
        logic [15:0] data;
    } exp_t;

    exp_t cpu_q[$];
    exp_t aux_q[$];
    exp_t vid_q[$];

    int checks = 0;
    int failures = 0;
    int ticks = 0;
    int cpu_ack_cnt = 0, aux_ack_cnt = 0, vid_cnt = 0;
    int vid_tick = 0;
    logic [3:0]  cpu_ack_ph = '0, aux_ack_ph = '0, vid_ph = '0;
    logic [15:0] we_mask = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) if (cen_16) ticks++;

    // Output monitor: pops the scoreboard whenever a master is acknowledged.
    always @(negedge clk) begin
        exp_t e;
        if (RESET_N) begin
            if (ram_we) we_mask[phase] = 1'b1;
            if (cpu_ack) begin
                cpu_ack_cnt++;
                cpu_ack_ph = phase;
                if (cpu_q.size() == 0) check("cpu_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = cpu_q.pop_front();
                    if (e.chk) check("cpu_rdata", {24'd0, cpu_rdata}, {16'd0, e.data});
                end
            end
            if (aux_ack) begin
                aux_ack_cnt++;
                aux_ack_ph = phase;
                if (aux_q.size() == 0) check("aux_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = aux_q.pop_front();
                    if (e.chk) check("aux_rdata", {24'd0, aux_rdata}, {16'd0, e.data});
                end
            end
            if (vid_strobe) begin
                vid_cnt++;
                vid_ph = phase;
                vid_tick = ticks;
                if (vid_q.size() == 0) check("vid_strobe_unexpected", 32'd1, 32'd0);
                else begin
                    e = vid_q.pop_front();
                    check("vid_data", {16'd0, vid_data}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic wait_phase(input logic [3:0] p, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (phase == p) hit = 1'b1;
        end
        check({tag, "_phase_reached"}, {31'd0, hit}, 32'd1);
    endtask

    function automatic int event_cnt(input int which);
        case (which)
            0:       return cpu_ack_cnt;
            1:       return aux_ack_cnt;
            default: return vid_cnt;
        endcase
    endfunction

    // which: 0 = cpu_ack, 1 = aux_ack, 2 = vid_strobe
    task automatic wait_event(input int which, input string tag);
        int  start;
        bit  hit;
        start = event_cnt(which);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (event_cnt(which) != start) hit = 1'b1;
        end
        check({tag, "_seen"}, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        int t0;
        int first_vid_tick;

        // Reset state
        vid_en   = 1'b1;
        vid_addr = 15'h1000;
        repeat (4) @(negedge clk);
        check("rst_phase", {28'd0, phase}, 32'd0);
        check("rst_owner", {30'd0, owner}, 32'd0);
        check("rst_ram_oe", {31'd0, ram_oe}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
        check("rst_vid_data", {16'd0, vid_data}, 32'd0);
        check("rst_acks", {29'd0, cpu_ack, aux_ack, vid_strobe}, 32'd0);

        // Video fetch: two frames of {0x2001,0x2000}
        vid_q.push_back('{1'b1, 16'h5AA5});
        vid_q.push_back('{1'b1, 16'h5AA5});
        RESET_N = 1'b1;
        t0 = ticks;
        wait_event(2, "vid1");
        first_vid_tick = vid_tick;
        check("vid1_phase", {28'd0, vid_ph}, 32'd12);
        check("vid1_ticks_from_reset", vid_tick - t0, 32'd12);
        @(negedge clk);
        check("vid_strobe_one_clk", {31'd0, vid_strobe}, 32'd0);
        wait_phase(4'd8, "vid_odd_slot");
        check("vid_odd_owner", {30'd0, owner}, 32'd1);
        check("vid_odd_addr", {16'd0, ram_addr}, 32'h2001);
        check("vid_odd_oe", {31'd0, ram_oe}, 32'd1);
        wait_event(2, "vid2");
        check("vid_period_ticks", vid_tick - first_vid_tick, 32'd16);
        vid_en = 1'b0;

        // CPU read from inside the frame before slot 1
        wait_phase(4'd2, "cpu_rd");
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
        cpu_q.push_back('{1'b1, 16'h003C});
        wait_event(0, "cpu_rd_ack");
        check("cpu_rd_ack_phase", {28'd0, cpu_ack_ph}, 32'd8);
        cpu_req = 1'b0;
        @(negedge clk);
        check("cpu_ack_one_clk", {31'd0, cpu_ack}, 32'd0);

        // Request arriving just after the slot-1 grant waits for the next frame
        wait_phase(4'd4, "cpu_late");
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
        cpu_q.push_back('{1'b1, 16'h00A5});
        t0 = ticks;
        wait_event(0, "cpu_late_ack");
        check("cpu_late_ack_phase", {28'd0, cpu_ack_ph}, 32'd8);
        check("cpu_late_waits_frame", {31'd0, ((ticks - t0) >= 16) && ((ticks - t0) <= 20)}, 32'd1);
        cpu_req = 1'b0;

        // CPU write: ram_we only during ticks 1-2 of slot 1
        wait_phase(4'd2, "cpu_wr");
        we_mask = '0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'h77;
        cpu_q.push_back('{1'b0, 16'h0000});
        wait_event(0, "cpu_wr_ack");
        cpu_req = 1'b0; cpu_we = 1'b0;
        check("cpu_wr_we_phases", {16'd0, we_mask}, 32'h0060);
        check("cpu_wr_mem", {24'd0, mem[16'h8000]}, 32'h77);
        wait_phase(4'd2, "cpu_rdback");
        cpu_req = 1'b1; cpu_addr = 16'h8000;
        cpu_q.push_back('{1'b1, 16'h0077});
        wait_event(0, "cpu_rdback_ack");
        cpu_req = 1'b0;

        // CPU and AUX together: CPU first, AUX later
        wait_phase(4'd2, "both");
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2001;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h4000;
        cpu_q.push_back('{1'b1, 16'h005A});
        aux_q.push_back('{1'b1, 16'h003C});
        wait_event(0, "both_cpu_ack");
        check("both_cpu_ack_phase", {28'd0, cpu_ack_ph}, 32'd8);
        cpu_req = 1'b0;
        wait_event(1, "both_aux_ack");
`ifdef AUX_STEAL_EN
        check("both_aux_ack_phase", {28'd0, aux_ack_ph}, 32'd12);
`else
        check("both_aux_ack_phase", {28'd0, aux_ack_ph}, 32'd0);
`endif
        aux_req = 1'b0;

        // AUX alone after its slot has passed, video disabled
        wait_phase(4'd14, "aux_only");
        aux_req = 1'b1; aux_addr = 16'h2000;
        aux_q.push_back('{1'b1, 16'h00A5});
        wait_phase(4'd0, "aux_only_slot0");
`ifdef AUX_STEAL_EN
        check("aux_only_owner_ph0", {30'd0, owner}, 32'd3);
`else
        check("aux_only_owner_ph0", {30'd0, owner}, 32'd0);
`endif
        wait_event(1, "aux_only_ack");
`ifdef AUX_STEAL_EN
        check("aux_only_ack_phase", {28'd0, aux_ack_ph}, 32'd4);
`else
        check("aux_only_ack_phase", {28'd0, aux_ack_ph}, 32'd0);
`endif
        aux_req = 1'b0;

        // Reset in the middle of a CPU write aborts it without ack
        wait_phase(4'd2, "abort");
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h9000; cpu_wdata = 8'h11;
        wait_phase(4'd5, "abort_mid");
        check("abort_we_active", {31'd0, ram_we}, 32'd1);
        t0 = cpu_ack_cnt;
        RESET_N = 1'b0;
        @(negedge clk);
        check("abort_phase", {28'd0, phase}, 32'd0);
        check("abort_ram_we", {31'd0, ram_we}, 32'd0);
        check("abort_owner", {30'd0, owner}, 32'd0);
        check("abort_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        RESET_N = 1'b1;
        repeat (80) @(negedge clk);
        check("abort_no_ack", cpu_ack_cnt - t0, 32'd0);

        check("cpu_q_drained", cpu_q.size(), 32'd0);
        check("aux_q_drained", aux_q.size(), 32'd0);
        check("vid_q_drained", vid_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
